operand_fetch: RTL and testbench
================================

# operand_fetch

Sequences a decoded instruction's source-register reads through the single-port register file (one address per cycle, combinational read, synchronous write). It sits directly upstream of the register file, owns its address, write-enable and write-data inputs, and arbitrates between operand reads and retiring writebacks. Captured operands are handed downstream to execute over a valid/ready handshake.

## Interface
- WORD_SIZE, 32: data width.
- REG_COUNT, 32: architectural registers; AW = $clog2(REG_COUNT).

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_rs1  in  AW  first source index.
- in_rs2  in  AW  second source index.
- in_use_rs2  in  1  instruction reads rs2.
- out_valid  out  1  operands valid.
- out_ready  in  1  downstream accepts.
- out_op1  out  WORD_SIZE  rs1 value.
- out_op2  out  WORD_SIZE  rs2 value, or 0 when not used.
- wb_valid  in  1  writeback request.
- wb_ready  out  1  writeback accepted this cycle.
- wb_rd  in  AW  destination index.
- wb_data  in  WORD_SIZE  writeback value.
- rf_we  out  1  register-file write enable.
- rf_addr  out  AW  register-file shared address.
- rf_wdata  out  WORD_SIZE  register-file write data (= wb_data).
- rf_rdata  in  WORD_SIZE  register-file combinational read data; 0 for index 0.

## Operation
- FSM states: IDLE, RD1, RD2, DONE.
- IDLE: in_ready=1. On in_valid, latch rs1, rs2 and use_rs2, then go to RD1.
- RD1: rf_addr=rs1, capture out_op1 <= rf_rdata. Go to RD2 if use_rs2. Otherwise set out_op2 <= 0 and go to DONE.
- RD2: rf_addr=rs2, capture out_op2 <= rf_rdata, then go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE. out_op1 and out_op2 hold stable while out_valid.
- Port arbitration: reads own the port in RD1 and RD2, so wb_ready=0 there. In IDLE and DONE, wb_ready=1 and rf_addr=wb_rd.
- rf_we = wb_valid && wb_ready && (wb_rd != 0). A write to x0 completes the handshake but never asserts rf_we.
- Simultaneous in_valid and wb_valid in IDLE: both are accepted in the same cycle. The write lands at that edge, so a following RD1 reads the new value.
- Continuous writeback never starves reads. An in-flight instruction always progresses through RD1 and RD2.
- rf_addr is a don't-care when neither side uses the port; it is driven with the latched rs1.

## Timing
- Request accepted at edge N.
  - out_valid is asserted in cycle N+3 when use_rs2=1.
  - out_valid is asserted in cycle N+2 when use_rs2=0.
- in_ready is 0 from N+1 until the cycle after the out handshake. There is no overlap between instructions.
- Writeback latency: data is in the register file at the edge on which wb_valid && wb_ready.
- Reset (rst_n low, asynchronous):
  - state=IDLE, out_valid=0, out_op1=0, out_op2=0.
  - rf_we is forced to 0 while rst_n is low.
  - After release: in_ready=1, wb_ready=1.
- Reset mid-operation discards the latched instruction and operands. No partial out_valid is produced.

## Configuration
- OPFETCH_WB_BYPASS_EN defined:
  - In RD1 or RD2, if wb_valid, wb_rd equals the current read index, and wb_rd != 0, capture wb_data instead of rf_rdata.
  - The writeback stays stalled (wb_ready=0) and is retired later as normal.
- OPFETCH_WB_BYPASS_EN undefined: operands always come from rf_rdata. A stalled writeback to a source register yields the old value.

## Test plan
- Reset, then preload x5=0x1234 and x6=0xABCD via writeback in IDLE. Issue rs1=5, rs2=6, use_rs2=1 -> out_valid 3 cycles after accept with op1=0x1234, op2=0xABCD.
- Issue rs1=5, use_rs2=0 -> out_valid 2 cycles after accept with op1=0x1234, op2=0.
- Issue rs1=0, rs2=0. Also write wb_rd=0, wb_data=0xFFFF -> rf_we stays 0, wb_ready handshake completes, op1=op2=0.
- Hold wb_valid with wb_rd=6, data 0x55 during RD1/RD2 -> wb_ready=0 in both cycles. Result:
  - op2=0x55 with the bypass macro defined.
  - op2=0xABCD without it.
  - In both cases x6=0x55 after DONE.
- Hold out_ready=0 for 4 cycles in DONE with wb traffic -> operands stay stable, in_ready=0, writes are accepted.
- Assert rst_n low during RD2 -> out_valid never rises. After release, in_ready=1 and the outputs are 0.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch: sequences rs1/rs2 reads through a single-port register file and
// arbitrates the port with retiring writebacks. Optional macro: OPFETCH_WB_BYPASS_EN.
module operand_fetch #(
    parameter int WORD_SIZE = 32,
    parameter int REG_COUNT = 32,
    localparam int AW = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        in_rs1,
    input  logic [AW-1:0]        in_rs2,
    input  logic                 in_use_rs2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_op1,
    output logic [WORD_SIZE-1:0] out_op2,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [AW-1:0]        wb_rd,
    input  logic [WORD_SIZE-1:0] wb_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_addr,
    output logic [WORD_SIZE-1:0] rf_wdata,
    input  logic [WORD_SIZE-1:0] rf_rdata
);

    typedef enum logic [1:0] {IDLE, RD1, RD2, DONE} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          rs1_q, rs1_d;
    logic [AW-1:0]          rs2_q, rs2_d;
    logic                   use_rs2_q, use_rs2_d;
    logic [WORD_SIZE-1:0]   op1_q, op1_d;
    logic [WORD_SIZE-1:0]   op2_q, op2_d;

    logic                   port_free;
    logic [AW-1:0]          rd_idx;
    logic [WORD_SIZE-1:0]   rd_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_rs2_q <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_rs2_q <= use_rs2_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
        end
    end

    // Writebacks only get the port while no read is in flight, so reads never starve.
    always_comb begin
        port_free = (state_q == IDLE) || (state_q == DONE);
        rd_idx    = (state_q == RD2) ? rs2_q : rs1_q;
`ifdef OPFETCH_WB_BYPASS_EN
        rd_val = (wb_valid && (wb_rd == rd_idx) && (wb_rd != '0)) ? wb_data : rf_rdata;
`else
        rd_val = rf_rdata;
`endif
    end

    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_rs2_d = use_rs2_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rs1_d     = in_rs1;
                    rs2_d     = in_rs2;
                    use_rs2_d = in_use_rs2;
                    state_d   = RD1;
                end
            end
            RD1: begin
                op1_d = rd_val;
                if (use_rs2_q) begin
                    state_d = RD2;
                end else begin
                    op2_d   = '0;
                    state_d = DONE;
                end
            end
            RD2: begin
                op2_d   = rd_val;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign wb_ready  = port_free;
    // x0 writes complete the handshake but never touch the file.
    assign rf_we     = rst_n && wb_valid && port_free && (wb_rd != '0);
    assign rf_addr   = port_free ? (wb_valid ? wb_rd : rs1_q) : rd_idx;
    assign rf_wdata  = wb_data;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: bench-owned register file, architectural
// reference array, directed scenarios followed by randomized instructions.
module tb_operand_fetch;
    localparam int W  = 32;
    localparam int AW = 5;
`ifdef OPFETCH_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_use_rs2;
    logic [AW-1:0] in_rs1, in_rs2;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_op1, out_op2;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_rd;
    logic [W-1:0]  wb_data;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [W-1:0]  rf_wdata, rf_rdata;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] rf_mem   [32];
    logic [W-1:0] ref_regs [32];
    logic         clr_rf;

    always #5 clk = ~clk;

    operand_fetch #(.WORD_SIZE(W), .REG_COUNT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs2(in_use_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Register file: combinational read with x0 hard-wired, synchronous write.
    assign rf_rdata = (rf_addr == '0) ? '0 : rf_mem[rf_addr];
    always @(posedge clk) begin
        if (clr_rf) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [AW-1:0] rd, input logic [W-1:0] data);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        #1;
        chk("wb_ready_idle", {31'b0, wb_ready}, 1);
        chk("rf_we_idle", {31'b0, rf_we}, {31'b0, (rd != '0)});
        tick;
        wb_valid = 1'b0;
        if (rd != '0) ref_regs[rd] = data;
    endtask

    // mode 0: no writeback; 1: writeback alongside accept; 2: writeback held through reads
    task automatic do_instr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic use2,
                            input int mode, input logic [AW-1:0] wrd, input logic [W-1:0] wdat,
                            input int stall);
        logic [W-1:0] e1, e2;
        int st;
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_rs2 = use2;
        out_ready  = 1'b0;
        if (mode == 1) begin
            wb_valid = 1'b1;
            wb_rd    = wrd;
            wb_data  = wdat;
        end
        #1;
        chk("in_ready_accept", {31'b0, in_ready}, 1);
        if (mode == 1) begin
            chk("wb_ready_simul", {31'b0, wb_ready}, 1);
            chk("rf_we_simul", {31'b0, rf_we}, {31'b0, (wrd != '0)});
        end
        tick;
        in_valid   = 1'b0;
        in_rs1     = AW'($urandom);
        in_rs2     = AW'($urandom);
        in_use_rs2 = 1'($urandom);
        if (mode == 1) begin
            wb_valid = 1'b0;
            if (wrd != '0) ref_regs[wrd] = wdat;
        end
        e1 = (mode == 2 && BYP && wrd == rs1 && wrd != '0) ? wdat : ref_regs[rs1];
        e2 = !use2 ? '0 : (mode == 2 && BYP && wrd == rs2 && wrd != '0) ? wdat : ref_regs[rs2];
        if (mode == 2) begin
            wb_valid = 1'b1;
            wb_rd    = wrd;
            wb_data  = wdat;
        end
        #1;
        chk("out_valid_n1", {31'b0, out_valid}, 0);
        chk("in_ready_busy", {31'b0, in_ready}, 0);
        if (mode == 2) begin
            chk("wb_stall_rd1", {31'b0, wb_ready}, 0);
            chk("rf_we_rd1", {31'b0, rf_we}, 0);
        end
        tick;
        if (use2) begin
            #1;
            chk("out_valid_n2", {31'b0, out_valid}, 0);
            if (mode == 2) chk("wb_stall_rd2", {31'b0, wb_ready}, 0);
            tick;
        end
        #1;
        chk("out_valid_latency", {31'b0, out_valid}, 1);
        st = (mode == 2 && stall < 1) ? 1 : stall;
        for (int s = 0; s < st; s++) begin
            chk("stall_valid", {31'b0, out_valid}, 1);
            chk("stall_op1", out_op1, e1);
            chk("stall_op2", out_op2, e2);
            chk("stall_in_ready", {31'b0, in_ready}, 0);
            if (mode == 2 && s == 0) begin
                chk("wb_retire_ready", {31'b0, wb_ready}, 1);
                chk("wb_retire_we", {31'b0, rf_we}, {31'b0, (wrd != '0)});
                tick;
                wb_valid = 1'b0;
                if (wrd != '0) ref_regs[wrd] = wdat;
            end else if ($urandom_range(0, 1) == 1) begin
                logic [AW-1:0] r;
                logic [W-1:0]  d;
                r = AW'($urandom);
                d = $urandom;
                wb_valid = 1'b1;
                wb_rd    = r;
                wb_data  = d;
                #1;
                chk("wb_ready_done", {31'b0, wb_ready}, 1);
                tick;
                wb_valid = 1'b0;
                if (r != '0) ref_regs[r] = d;
            end else begin
                tick;
            end
        end
        out_ready = 1'b1;
        #1;
        chk("out_valid_hs", {31'b0, out_valid}, 1);
        chk("op1", out_op1, e1);
        chk("op2", out_op2, e2);
        tick;
        out_ready = 1'b0;
        chk("out_valid_after", {31'b0, out_valid}, 0);
        chk("in_ready_after", {31'b0, in_ready}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clr_rf = 1'b1;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_use_rs2 = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        #12;
        chk("rst_rf_we", {31'b0, rf_we}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_op1", out_op1, 0);
        chk("rst_op2", out_op2, 0);
        wb_valid = 1'b0;
        #5;
        clr_rf = 1'b0;
        rst_n  = 1'b1;
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 1);
        chk("rel_wb_ready", {31'b0, wb_ready}, 1);
        tick;

        wb_write(5'd5, 32'h1234);
        wb_write(5'd6, 32'hABCD);
        do_instr(5'd5, 5'd6, 1'b1, 0, 5'd0, 32'h0, 0);
        do_instr(5'd5, 5'd9, 1'b0, 0, 5'd0, 32'h0, 0);
        do_instr(5'd0, 5'd0, 1'b1, 1, 5'd0, 32'hFFFF, 0);
        do_instr(5'd7, 5'd5, 1'b1, 1, 5'd7, 32'h777, 1);
        do_instr(5'd5, 5'd6, 1'b1, 2, 5'd6, 32'h55, 4);
        chk("x6_after_retire", rf_mem[6], 32'h55);

        // Reset while RD2 is in progress.
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_use_rs2 = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        #2;
        rst_n = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_op1", out_op1, 0);
        chk("midrst_op2", out_op2, 0);
        chk("midrst_rf_we", {31'b0, rf_we}, 0);
        tick;
        chk("midrst_hold_valid", {31'b0, out_valid}, 0);
        tick;
        wb_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", {31'b0, in_ready}, 1);
        chk("postrst_wb_ready", {31'b0, wb_ready}, 1);
        chk("postrst_op1", out_op1, 0);
        chk("postrst_op2", out_op2, 0);
        tick;
        chk("postrst_no_valid", {31'b0, out_valid}, 0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) wb_write(AW'($urandom), $urandom);
            do_instr(AW'($urandom), AW'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                     AW'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 32; i++) chk("rf_contents", rf_mem[i], ref_regs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
